// File: rtl/parity_frame_chk.sv
// -----------------------------------------------------------------------------
// parity_frame_chk
//
// Streaming parity checker. WIDTH-bit words arrive over a valid/ready
// handshake and their parity is accumulated across frames of FRAME_LEN words.
// Each finished frame is checked against the odd/even mode captured on the
// frame's first word. The result is presented through a registered valid/ready
// output. Failing frames bump a saturating error counter.
//
// State table:
//   state | meaning
//   IDLE  | no partial frame; word_cnt = 0, acc = 0; next word starts a frame
//   ACCUM | 0 < word_cnt < FRAME_LEN words of the current frame absorbed
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   sel        in   1 = odd parity expected, 0 = even; sampled on first word
//   in_valid   in   in_data valid
//   in_ready   out  block can accept a word (low only while a result stalls)
//   in_data    in   WIDTH-bit data word
//   flush      in   synchronous discard of the partial frame
//   out_valid  out  frame result valid
//   out_ready  in   consumer accepts the result
//   out_check  out  1 = frame parity matches latched mode
//   out_parity out  XOR of all bits of the frame
//   err_clr    in   synchronous clear of err_cnt (wins over an increment)
//   err_cnt    out  saturating count of failing frames
// -----------------------------------------------------------------------------
module parity_frame_chk #(
  parameter int WIDTH     = 32,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_check,
  output logic             out_parity,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  // Counter is kept at least one bit wide so FRAME_LEN == 1 still elaborates.
  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0]    LAST_IDX = CW'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     word_cnt_q, word_cnt_d;
  logic              acc_q, acc_d;
  logic              mode_q, mode_d;
  logic              out_valid_q, out_valid_d;
  logic              out_check_q, out_check_d;
  logic              out_parity_q, out_parity_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic              xfer;
  logic              word_par;
  logic              frame_done;
  logic              frame_par;
  logic              frame_mode;
  logic              frame_check;

  // A finishing frame always transfers with in_ready high, so the output
  // register is either empty or being drained in that same cycle.
  assign in_ready = ~(out_valid_q & ~out_ready);
  assign xfer     = in_valid & in_ready;
  assign word_par = ^in_data;

  // ---------------------------------------------------------------------------
  // Frame FSM: next state and accumulator
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    acc_d      = acc_q;
    mode_d     = mode_q;
    frame_done = 1'b0;
    frame_par  = acc_q ^ word_par;
    frame_mode = mode_q;

    if (flush) begin
      // Any word transferred alongside flush is dropped with the partial frame.
      state_d    = IDLE;
      word_cnt_d = '0;
      acc_d      = 1'b0;
    end else if (xfer) begin
      unique case (state_q)
        IDLE: begin
          mode_d     = sel;
          frame_par  = word_par;
          frame_mode = sel;
          if (FRAME_LEN == 1) begin
            frame_done = 1'b1;
          end else begin
            state_d    = ACCUM;
            word_cnt_d = CW'(1);
            acc_d      = word_par;
          end
        end
        ACCUM: begin
          if (word_cnt_q == LAST_IDX) begin
            frame_done = 1'b1;
            state_d    = IDLE;
            word_cnt_d = '0;
            acc_d      = 1'b0;
          end else begin
            word_cnt_d = word_cnt_q + CW'(1);
            acc_d      = frame_par;
          end
        end
        default: begin
          state_d    = IDLE;
          word_cnt_d = '0;
          acc_d      = 1'b0;
        end
      endcase
    end
  end

  assign frame_check = frame_mode ? frame_par : ~frame_par;

  // ---------------------------------------------------------------------------
  // Result register and error counter
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid_d  = out_valid_q;
    out_check_d  = out_check_q;
    out_parity_d = out_parity_q;
    err_cnt_d    = err_cnt_q;

    if (frame_done) begin
      out_valid_d  = 1'b1;
      out_check_d  = frame_check;
      out_parity_d = frame_par;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (err_clr) begin
      err_cnt_d = '0;
    end else if (frame_done && !frame_check && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      acc_q        <= 1'b0;
      mode_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_check_q  <= 1'b0;
      out_parity_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      acc_q        <= acc_d;
      mode_q       <= mode_d;
      out_valid_q  <= out_valid_d;
      out_check_q  <= out_check_d;
      out_parity_q <= out_parity_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_check  = out_check_q;
  assign out_parity = out_parity_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_parity_frame_chk.sv
// -----------------------------------------------------------------------------
// tb_parity_frame_chk
//
// Directed bench for parity_frame_chk with WIDTH = 32, FRAME_LEN = 4 and a
// 2-bit error counter so saturation is reachable. Inputs change 1 ns after
// the rising edge; outputs are sampled in that same window.
// -----------------------------------------------------------------------------
module tb_parity_frame_chk;

  localparam int WIDTH     = 32;
  localparam int FRAME_LEN = 4;
  localparam int CNT_W     = 2;

  logic             clk;
  logic             rst_n;
  logic             sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             out_check;
  logic             out_parity;
  logic             err_clr;
  logic [CNT_W-1:0] err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  parity_frame_chk #(
    .WIDTH    (WIDTH),
    .FRAME_LEN(FRAME_LEN),
    .CNT_W    (CNT_W)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_check (out_check),
    .out_parity(out_parity),
    .err_clr   (err_clr),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One word transfer; waits (bounded) for in_ready, returns 1 ns after the
  // transferring edge with in_valid dropped.
  task automatic push(input logic [31:0] d, input logic s);
    int cyc;
    in_data  = d;
    sel      = s;
    in_valid = 1'b1;
    cyc      = 0;
    while (!in_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    if (!in_ready) chk("push_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic par, input logic ck,
                            input logic [CNT_W-1:0] ec);
    chk({tag, "_valid"},  32'(out_valid),  32'd1);
    chk({tag, "_parity"}, 32'(out_parity), 32'(par));
    chk({tag, "_check"},  32'(out_check),  32'(ck));
    chk({tag, "_err"},    32'(err_cnt),    32'(ec));
  endtask

  initial begin
    rst_n     = 1'b0;
    sel       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    #12;
    chk("rst_valid",  32'(out_valid),  32'd0);
    chk("rst_check",  32'(out_check),  32'd0);
    chk("rst_parity", 32'(out_parity), 32'd0);
    chk("rst_err",    32'(err_cnt),    32'd0);
    chk("rst_ready",  32'(in_ready),   32'd1);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();

    // Even mode: 1,2,3,4 carry five ones -> parity 1, check fails.
    push(32'd1, 1'b0);
    push(32'd2, 1'b0);
    push(32'd3, 1'b0);
    chk("even_early", 32'(out_valid), 32'd0);
    push(32'd4, 1'b0);
    chk_result("even", 1'b1, 1'b0, 2'd1);
    tick();
    chk("even_drain", 32'(out_valid), 32'd0);

    // Odd mode latched on word 1; later sel changes ignored.
    push(32'd1, 1'b1);
    push(32'd2, 1'b0);
    push(32'd3, 1'b0);
    push(32'd4, 1'b0);
    chk_result("odd", 1'b1, 1'b1, 2'd1);
    tick();

    // Backpressure: frame A (parity 1, even -> fail) held while B waits.
    out_ready = 1'b0;
    push(32'd0, 1'b0);
    push(32'd0, 1'b0);
    push(32'd0, 1'b0);
    push(32'd1, 1'b0);
    chk_result("bp_a", 1'b1, 1'b0, 2'd2);
    in_data  = 32'd7;
    sel      = 1'b1;
    in_valid = 1'b1;
    tick();
    tick();
    tick();
    chk("bp_stall_ready", 32'(in_ready), 32'd0);
    chk_result("bp_a_hold", 1'b1, 1'b0, 2'd2);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_a_taken", 32'(out_valid), 32'd0);
    push(32'd0, 1'b0);
    push(32'd0, 1'b0);
    chk("bp_b_early", 32'(out_valid), 32'd0);
    push(32'd0, 1'b0);
    // B: 0x7 has three ones, odd mode from word 1 -> passes.
    chk_result("bp_b", 1'b1, 1'b1, 2'd2);
    tick();

    // Flush of a partial frame, then a clean all-zero even frame.
    push(32'hFFFF_FFFF, 1'b0);
    push(32'hFFFF_FFFF, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    push(32'd0, 1'b0);
    chk("fl_w1", 32'(out_valid), 32'd0);
    push(32'd0, 1'b0);
    chk("fl_w2", 32'(out_valid), 32'd0);
    push(32'd0, 1'b0);
    chk("fl_w3", 32'(out_valid), 32'd0);
    push(32'd0, 1'b0);
    chk_result("fl", 1'b0, 1'b1, 2'd2);
    tick();
    chk("fl_single", 32'(out_valid), 32'd0);

    // Flush coinciding with the last word: frame dropped, no result.
    push(32'd1, 1'b0);
    push(32'd0, 1'b0);
    push(32'd0, 1'b0);
    flush = 1'b1;
    push(32'd0, 1'b0);
    flush = 1'b0;
    chk("fl_last_valid", 32'(out_valid), 32'd0);
    chk("fl_last_err",   32'(err_cnt),   32'd2);
    push(32'd8, 1'b1);
    push(32'd0, 1'b0);
    push(32'd0, 1'b0);
    chk("fl_realign", 32'(out_valid), 32'd0);
    push(32'd0, 1'b0);
    chk_result("fl_after", 1'b1, 1'b1, 2'd2);
    tick();

    // Saturation and clear.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr", 32'(err_cnt), 32'd0);
    for (int f = 1; f <= 5; f++) begin
      push(32'd1, 1'b0);
      push(32'd0, 1'b0);
      push(32'd0, 1'b0);
      push(32'd0, 1'b0);
      chk_result($sformatf("sat%0d", f), 1'b1, 1'b0, (f >= 3) ? 2'd3 : 2'(f));
    end
    push(32'd1, 1'b0);
    push(32'd0, 1'b0);
    push(32'd0, 1'b0);
    err_clr = 1'b1;
    push(32'd0, 1'b0);
    err_clr = 1'b0;
    chk_result("clr_prio", 1'b1, 1'b0, 2'd0);
    push(32'd1, 1'b0);
    push(32'd0, 1'b0);
    push(32'd0, 1'b0);
    push(32'd0, 1'b0);
    chk_result("after_clr", 1'b1, 1'b0, 2'd1);
    tick();

    // Reset with a passing result pending.
    out_ready = 1'b0;
    push(32'd1, 1'b1);
    push(32'd0, 1'b0);
    push(32'd0, 1'b0);
    push(32'd0, 1'b0);
    chk_result("pend", 1'b1, 1'b1, 2'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid",  32'(out_valid),  32'd0);
    chk("arst_check",  32'(out_check),  32'd0);
    chk("arst_parity", 32'(out_parity), 32'd0);
    chk("arst_err",    32'(err_cnt),    32'd0);
    chk("arst_ready",  32'(in_ready),   32'd1);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Reset mid-frame: partial words (parity 1) must be lost.
    push(32'd1, 1'b0);
    push(32'd3, 1'b0);
    #2;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    push(32'd1, 1'b0);
    push(32'd0, 1'b0);
    chk("mid_rst_early", 32'(out_valid), 32'd0);
    push(32'd0, 1'b0);
    chk("mid_rst_w3", 32'(out_valid), 32'd0);
    push(32'd0, 1'b0);
    chk_result("mid_rst", 1'b1, 1'b0, 2'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
